// File: rtl/rr_arb_enc4.sv
// rr_arb_enc4: four-requester round-robin arbiter with a registered 2-bit
// grant index and a matching one-hot copy. Grants are held until the owner
// signals done, withdraws its request, or the optional hold limit expires.
// Every grant is followed by at least one idle cycle so the downstream select
// only changes while the grant is invalid.
module rr_arb_enc4 #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic       gnt_valid,
  output logic [1:0] gnt_idx,
  output logic [3:0] gnt_onehot,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Last hold_cnt value allowed before a forced release; unused when the
  // limit is disabled (MAX_HOLD == 0).
  localparam int               HOLD_LAST_I = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_LAST_I);
  localparam bit               HOLD_EN     = (MAX_HOLD != 0);

  state_t            state;
  logic [1:0]        ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic [1:0] winner;
  logic       limit_hit;
  logic       rel;

  // First requester found scanning p, p+1, p+2, p+3 (mod 4). The scan runs
  // from the far end back toward p so the nearest hit is the last written.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] w;
    logic [1:0] c;
    w = p;
    for (int k = 3; k >= 0; k--) begin
      c = p + 2'(k);
      if (r[c]) w = c;
    end
    return w;
  endfunction

  // Saturating increment so an unlimited hold never wraps the counter.
  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
    if (&v) return v;
    return v + HOLD_W'(1);
  endfunction

  function automatic logic [3:0] to_onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  // Winner selection and release decision for the current cycle.
  always_comb begin
    winner    = rr_pick(req, ptr);
    limit_hit = HOLD_EN && (hold_cnt == HOLD_LAST);
    rel       = done || !req[gnt_idx] || limit_hit;
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      hold_cnt   <= '0;
      gnt_valid  <= 1'b0;
      gnt_idx    <= 2'd0;
      gnt_onehot <= 4'b0000;
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state      <= GRANT;
            gnt_valid  <= 1'b1;
            gnt_idx    <= winner;
            gnt_onehot <= to_onehot(winner);
            hold_cnt   <= '0;
          end
        end
        GRANT: begin
          hold_cnt <= sat_inc(hold_cnt);
          if (rel) begin
            state      <= IDLE;
            gnt_valid  <= 1'b0;
            gnt_onehot <= 4'b0000;
            ptr        <= gnt_idx + 2'd1;
            // Flag only releases caused by the hold limit alone.
            timeout    <= limit_hit && !done && req[gnt_idx];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb_enc4.sv
// Testbench for rr_arb_enc4: directed scenarios with literal expectations
// plus a randomized phase, all compared every cycle against a behavioural
// model of the arbitration rules.
module tb_rr_arb_enc4;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic [3:0] gnt_onehot;
  logic       timeout;

  int checks;
  int failures;

  rr_arb_enc4 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: who holds the resource, for how many cycles so far,
  // and where the next round-robin scan starts.
  logic m_grant;
  int   m_idx;
  int   m_ptr;
  int   m_held;
  logic m_to;
  logic m_lim;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_grant <= 1'b0;
      m_idx   <= 0;
      m_ptr   <= 0;
      m_held  <= 0;
      m_to    <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (!m_grant) begin
        if (req != 4'b0000) begin
          m_grant <= 1'b1;
          m_idx   <= pick(req, m_ptr);
          m_held  <= 1;
        end
      end else begin
        m_lim = (MAX_HOLD != 0) && (m_held >= MAX_HOLD);
        if (done || !req[m_idx] || m_lim) begin
          m_grant <= 1'b0;
          m_ptr   <= (m_idx + 1) % 4;
          m_to    <= m_lim && !done && req[m_idx];
        end else begin
          m_held <= m_held + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_cmp();
    check("mdl_valid",  8'(gnt_valid),  8'(m_grant));
    check("mdl_idx",    8'(gnt_idx),    8'(m_idx));
    check("mdl_onehot", 8'(gnt_onehot), m_grant ? 8'(1 << m_idx) : 8'd0);
    check("mdl_timeout", 8'(timeout),   8'(m_to));
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [1:0] i,
                            input logic [3:0] oh, input logic t);
    check({tag, "_valid"},   8'(gnt_valid),  8'(v));
    check({tag, "_idx"},     8'(gnt_idx),    8'(i));
    check({tag, "_onehot"},  8'(gnt_onehot), 8'(oh));
    check({tag, "_timeout"}, 8'(timeout),    8'(t));
  endtask

  // Advance to the next falling edge and compare against the model there.
  task automatic tick();
    @(negedge clk);
    model_cmp();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst  = 1'b0;
    req  = 4'b0000;
    done = 1'b0;
    #1 rst = 1'b1;
    tick();
    tick();
    expect_out("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
    rst = 1'b0;
    tick();
    expect_out("idle_noreq", 1'b0, 2'd0, 4'b0000, 1'b0);

    // Single requester 3, done on the third grant cycle.
    req = 4'b1000;
    tick(); expect_out("single_c1", 1'b1, 2'd3, 4'b1000, 1'b0);
    tick(); expect_out("single_c2", 1'b1, 2'd3, 4'b1000, 1'b0);
    tick(); expect_out("single_c3", 1'b1, 2'd3, 4'b1000, 1'b0);
    done = 1'b1;
    tick(); expect_out("single_gap", 1'b0, 2'd3, 4'b0000, 1'b0);
    done = 1'b0;

    // Pointer wrapped to 0: 0101 grants 0, then 2.
    req = 4'b0101;
    tick(); expect_out("wrap_g0", 1'b1, 2'd0, 4'b0001, 1'b0);
    done = 1'b1;
    tick(); expect_out("wrap_gap", 1'b0, 2'd0, 4'b0000, 1'b0);
    done = 1'b0;
    tick(); expect_out("skip_g2", 1'b1, 2'd2, 4'b0100, 1'b0);
    done = 1'b1;
    tick(); expect_out("skip_gap", 1'b0, 2'd2, 4'b0000, 1'b0);
    done = 1'b0;
    req  = 4'b0000;
    tick();

    // Round robin from a fresh pointer with all requests and done held.
    do_reset();
    req  = 4'b1111;
    done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); expect_out("rr_grant", 1'b1, 2'(i % 4), 4'(1 << (i % 4)), 1'b0);
      tick(); expect_out("rr_gap", 1'b0, 2'(i % 4), 4'b0000, 1'b0);
    end
    done = 1'b0;
    req  = 4'b0000;
    tick();

    // Asynchronous reset in the middle of a grant to 2.
    do_reset();
    req = 4'b0100;
    tick(); expect_out("pre_arst", 1'b1, 2'd2, 4'b0100, 1'b0);
    #2 rst = 1'b1;
    #1 expect_out("arst_mid", 1'b0, 2'd0, 4'b0000, 1'b0);
    tick();
    rst = 1'b0;
    tick(); expect_out("post_arst", 1'b1, 2'd2, 4'b0100, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b0000;
    tick();

    // Hold limit: requester 1 held with no done.
    req = 4'b0010;
    for (int i = 0; i < MAX_HOLD; i++) begin
      tick(); expect_out("hold_c", 1'b1, 2'd1, 4'b0010, 1'b0);
    end
    tick(); expect_out("hold_to", 1'b0, 2'd1, 4'b0000, 1'b1);
    for (int i = 0; i < MAX_HOLD; i++) begin
      tick(); expect_out("hold2_c", 1'b1, 2'd1, 4'b0010, 1'b0);
      if (i == MAX_HOLD - 1) done = 1'b1;
    end
    tick(); expect_out("hold_done", 1'b0, 2'd1, 4'b0000, 1'b0);
    done = 1'b0;

    // Withdrawal: grant to 1, req[1] drops while req[2] is up.
    tick(); expect_out("wd_g1", 1'b1, 2'd1, 4'b0010, 1'b0);
    req = 4'b0100;
    tick(); expect_out("wd_rel", 1'b0, 2'd1, 4'b0000, 1'b0);
    tick(); expect_out("wd_g2", 1'b1, 2'd2, 4'b0100, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b0000;
    tick();

    // Randomized phase with sticky requests and occasional async resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      done = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
